// File: rtl/icache_pkg.sv
// Shared types and parameter-derived sizes for the dual-fetch instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        DRAIN
    } state_t;

    function automatic int line_w(input int ofst);
        return 8 << ofst;
    endfunction

    function automatic int words(input int ofst);
        return 1 << (ofst - 2);
    endfunction

    function automatic int tag_w(input int addr_w, input int ofst, input int indx);
        return addr_w - ofst - indx;
    endfunction

endpackage

// File: rtl/icache_refill_unit_if.sv
// Line-refill memory port: the cache is the master and raises req; memory answers with ack plus a full line.
interface icache_refill_unit_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [LINE_W-1:0] mem_line;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_line);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_line);
endinterface

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for a direct-mapped cache: two async read ports, one write port, bulk invalidate.
module icache_line_array
    import icache_pkg::*;
#(
    parameter int INDX   = 6,
    parameter int TAG_W  = tag_w(32, 5, 6),
    parameter int LINE_W = line_w(5)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              i_flush,
    input  logic              i_we,
    input  logic [INDX-1:0]   i_wr_idx,
    input  logic [TAG_W-1:0]  i_wr_tag,
    input  logic [LINE_W-1:0] i_wr_line,
    input  logic [INDX-1:0]   i_rd_idx1,
    input  logic [INDX-1:0]   i_rd_idx2,
    output logic              o_valid1,
    output logic [TAG_W-1:0]  o_tag1,
    output logic [LINE_W-1:0] o_line1,
    output logic              o_valid2,
    output logic [TAG_W-1:0]  o_tag2,
    output logic [LINE_W-1:0] o_line2
);
    localparam int LINES = 1 << INDX;

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [LINE_W-1:0] r_data [LINES];

    // Flush has priority over a same-cycle write so an aborted fill never lands.
    always_ff @(posedge CLK) begin
        if (RESET || i_flush) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays carry no reset; the valid bits alone decide whether their contents mean anything.
    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_line;
        end
    end

    assign o_valid1 = r_valid[i_rd_idx1];
    assign o_tag1   = r_tag[i_rd_idx1];
    assign o_line1  = r_data[i_rd_idx1];
    assign o_valid2 = r_valid[i_rd_idx2];
    assign o_tag2   = r_tag[i_rd_idx2];
    assign o_line2  = r_data[i_rd_idx2];

endmodule

// File: rtl/icache_refill_unit.sv
// Dual-fetch direct-mapped I$ front end: same-cycle hit path for address and address+4,
// a req/ack line refill engine that survives mispredict/flush, and a saturating miss counter.
module icache_refill_unit
    import icache_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int OFST   = 5,
    parameter int INDX   = 6,
    parameter int CNT_W  = 16
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                SYS,
    input  logic                dread,
    input  logic [ADDR_W-1:0]   address,
    output logic [DATA_W-1:0]   data_out1,
    output logic [DATA_W-1:0]   data_out2,
    output logic                busy,
    output logic [1:0]          miss,
    input  logic                mispredict,
    input  logic                flush_all,
    icache_refill_unit_if.master mem,
    output logic [CNT_W-1:0]    miss_count
);
    localparam int LINE_W = line_w(OFST);
    localparam int WORDS  = words(OFST);
    localparam int TAG_W  = tag_w(ADDR_W, OFST, INDX);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFST) - 1);

    logic [ADDR_W-1:0] w_addr2;
    logic [INDX-1:0]   w_idx1, w_idx2;
    logic [TAG_W-1:0]  w_tag1, w_tag2, w_rtag1, w_rtag2;
    logic [OFST-3:0]   w_word1, w_word2;
    logic              w_valid1, w_valid2, w_hit1, w_hit2;
    logic [LINE_W-1:0] w_line1, w_line2;
    logic [DATA_W-1:0] w_words1 [WORDS];
    logic [DATA_W-1:0] w_words2 [WORDS];
    logic              w_want, w_abort, w_we;
    logic [ADDR_W-1:0] w_req_addr;

    state_t            r_state;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [INDX-1:0]   r_idx;
    logic [TAG_W-1:0]  r_tag;
    logic [LINE_W-1:0] r_line;
    logic [CNT_W-1:0]  r_cnt;

    // Slot 2 is a full address increment, so a line crossing at the last index also carries into the tag.
    assign w_addr2 = address + ADDR_W'(4);
    assign w_idx1  = address[OFST+INDX-1:OFST];
    assign w_tag1  = address[ADDR_W-1:OFST+INDX];
    assign w_word1 = address[OFST-1:2];
    assign w_idx2  = w_addr2[OFST+INDX-1:OFST];
    assign w_tag2  = w_addr2[ADDR_W-1:OFST+INDX];
    assign w_word2 = w_addr2[OFST-1:2];

    icache_line_array #(
        .INDX   (INDX),
        .TAG_W  (TAG_W),
        .LINE_W (LINE_W)
    ) u_array (
        .CLK       (CLK),
        .RESET     (RESET),
        .i_flush   (flush_all),
        .i_we      (w_we),
        .i_wr_idx  (r_idx),
        .i_wr_tag  (r_tag),
        .i_wr_line (r_line),
        .i_rd_idx1 (w_idx1),
        .i_rd_idx2 (w_idx2),
        .o_valid1  (w_valid1),
        .o_tag1    (w_rtag1),
        .o_line1   (w_line1),
        .o_valid2  (w_valid2),
        .o_tag2    (w_rtag2),
        .o_line2   (w_line2)
    );

    assign w_hit1 = w_valid1 && (w_rtag1 == w_tag1);
    assign w_hit2 = w_valid2 && (w_rtag2 == w_tag2);

    always_comb begin
        for (int w = 0; w < WORDS; w++) begin
            w_words1[w] = w_line1[w*DATA_W +: DATA_W];
            w_words2[w] = w_line2[w*DATA_W +: DATA_W];
        end
    end

    assign data_out1 = w_words1[w_word1];
    assign data_out2 = w_words2[w_word2];

    assign w_abort    = mispredict | flush_all;
    assign w_want     = dread & ~SYS & ~(w_hit1 & w_hit2);
    assign w_req_addr = (w_hit1 ? w_addr2 : address) & LINE_MASK;
    assign w_we       = (r_state == FILL) && !flush_all;

    assign miss = {~w_hit2, ~w_hit1} & {2{dread}};
    assign busy = w_want | (r_state != IDLE);

    // NOTE: every state register here uses <= so all of them update from the same pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_want && !w_abort) begin
                        r_state    <= REQ;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= w_req_addr;
                        r_idx      <= w_hit1 ? w_idx2 : w_idx1;
                        r_tag      <= w_hit1 ? w_tag2 : w_tag1;
                        if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                REQ: begin
                    if (mem.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_line    <= mem.mem_line;
                        r_state   <= w_abort ? IDLE : FILL;
                    end else if (w_abort) begin
                        r_state <= DRAIN;
                    end
                end
                FILL: r_state <= IDLE;
                DRAIN: begin
                    if (mem.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem.mem_req  = r_mem_req;
    assign mem.mem_addr = r_mem_addr;
    assign miss_count   = r_cnt;

endmodule
